// File: rtl/fetch_unit_pkg.sv
// Shared constants for the 4-bit multiplexed instruction bus: subcycle
// encoding, nibble/PC widths and the I/O opcode group.
package fetch_unit_pkg;

  localparam int NIB_W   = 4;
  localparam int PC_BITS = 12;

  localparam logic [NIB_W-1:0] OPR_IO = 4'hE;

  typedef enum logic [2:0] {
    CYC_A1 = 3'd0,
    CYC_A2 = 3'd1,
    CYC_A3 = 3'd2,
    CYC_M1 = 3'd3,
    CYC_M2 = 3'd4,
    CYC_X1 = 3'd5,
    CYC_X2 = 3'd6,
    CYC_X3 = 3'd7
  } cycle_e;

  // Address nibble driven in A1/A2/A3 (idx 0..2), low nibble first.
  function automatic logic [NIB_W-1:0] pc_nibble(input logic [PC_BITS-1:0] pc,
                                                 input logic [1:0]         idx);
    case (idx)
      2'd0:    return pc[3:0];
      2'd1:    return pc[7:4];
      default: return pc[11:8];
    endcase
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// 12-bit program counter: increments after the M2 capture, and a latched
// jump request replaces it at the end of X3 (last request wins).
module fetch_pc
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_BITS-1:0] RESET_PC = 12'h000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               halt,
  input  cycle_e             cycle,
  input  logic               pc_load,
  input  logic [PC_BITS-1:0] pc_load_addr,
  output logic [PC_BITS-1:0] pc
);

  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [PC_BITS-1:0] addr_q, addr_d;
  logic               pend_q, pend_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      addr_q <= '0;
      pend_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      addr_q <= addr_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    pc_d   = pc_q;
    addr_d = addr_q;
    pend_d = pend_q;
    if (!halt) begin
      if (pc_load) begin
        pend_d = 1'b1;
        addr_d = pc_load_addr;
      end
      if (cycle == CYC_M2) begin
        pc_d = pc_q + 12'd1;
      end
      // Checked after the increment so a load always wins; pend_d already
      // includes a request arriving in X3 itself.
      if (cycle == CYC_X3 && pend_d) begin
        pc_d   = addr_d;
        pend_d = 1'b0;
      end
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Bus master for the multiplexed instruction bus: sequences A1..X3, drives the
// PC nibbles, captures OPR/OPA and samples the bus in X2 for the execution stage.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_BITS-1:0] RESET_PC = 12'h000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               halt,
  input  logic [NIB_W-1:0]   data_i,
  output logic [NIB_W-1:0]   data_o,
  output logic               data_en,
  output logic               sync,
  output logic               cmd,
  input  logic               pc_load,
  input  logic [PC_BITS-1:0] pc_load_addr,
  output logic [7:0]         inst_o,
  output logic               inst_valid,
  output logic [2:0]         cycle_o,
  output logic [PC_BITS-1:0] pc_o,
  input  logic               exec_drive,
  input  logic [NIB_W-1:0]   exec_data,
  input  logic               exec_cmd,
  output logic [NIB_W-1:0]   x2_data_o,
  output logic               x2_valid
);

  // Strobes: inst_valid and x2_valid are single-cycle, no back-pressure; the
  // consumer must take inst_o / x2_data_o while the strobe is high (the data
  // registers hold afterwards). Both are masked while halt is high.

  cycle_e             cycle_q, cycle_d;
  logic [PC_BITS-1:0] pc;
  logic [NIB_W-1:0]   opr_q;
  logic [7:0]         inst_q;
  logic               inst_valid_q;
  logic [NIB_W-1:0]   x2_q;
  logic               x2_valid_q;
  logic               sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_q <= CYC_A1;
    else        cycle_q <= cycle_d;
  end

  always_comb begin
    cycle_d = cycle_q;
    if (!halt) cycle_d = cycle_e'(cycle_q + 3'd1);
  end

  fetch_pc #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clock       (clock),
    .reset       (reset),
    .halt        (halt),
    .cycle       (cycle_q),
    .pc_load     (pc_load),
    .pc_load_addr(pc_load_addr),
    .pc          (pc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opr_q        <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      x2_q         <= '0;
      x2_valid_q   <= 1'b0;
      sync_q       <= 1'b0;
    end else if (!halt) begin
      inst_valid_q <= (cycle_q == CYC_M2);
      sync_q       <= (cycle_q == CYC_X2);
      x2_valid_q   <= 1'b0;
      case (cycle_q)
        CYC_M1: opr_q  <= data_i;
        CYC_M2: inst_q <= {opr_q, data_i};
        CYC_X2: begin
          if (!exec_drive) begin
            x2_q       <= data_i;
            x2_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    data_o  = '0;
    data_en = 1'b0;
    cmd     = 1'b1;
    case (cycle_q)
      CYC_A1: begin
        data_en = 1'b1;
        data_o  = pc_nibble(pc, 2'd0);
      end
      CYC_A2: begin
        data_en = 1'b1;
        data_o  = pc_nibble(pc, 2'd1);
      end
      CYC_A3: begin
        data_en = 1'b1;
        data_o  = pc_nibble(pc, 2'd2);
        cmd     = 1'b0;
      end
      // I/O-group instructions select the chip so it can latch OPA.
      CYC_M2: cmd = (opr_q == OPR_IO) ? 1'b0 : 1'b1;
      CYC_X2: begin
        data_en = exec_drive;
        data_o  = exec_data;
        cmd     = ~exec_cmd;
      end
      CYC_X3: begin
        data_en = exec_drive;
        data_o  = exec_data;
      end
      default: ;
    endcase
  end

  assign sync       = sync_q;
  assign inst_o     = inst_q;
  assign inst_valid = inst_valid_q & ~halt;
  assign x2_data_o  = x2_q;
  assign x2_valid   = x2_valid_q & ~halt;
  assign cycle_o    = cycle_q;
  assign pc_o       = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a ROM that listens to the bus, plus a cycle-level
// reference of the instruction-cycle rules driven by directed and random steps.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        halt = 1'b0;
  logic [3:0]  data_i = '0;
  logic [3:0]  data_o;
  logic        data_en;
  logic        sync;
  logic        cmd;
  logic        pc_load = 1'b0;
  logic [11:0] pc_load_addr = '0;
  logic [7:0]  inst_o;
  logic        inst_valid;
  logic [2:0]  cycle_o;
  logic [11:0] pc_o;
  logic        exec_drive = 1'b0;
  logic [3:0]  exec_data = '0;
  logic        exec_cmd = 1'b0;
  logic [3:0]  x2_data_o;
  logic        x2_valid;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(12'h000)) dut (
    .clock       (clock),
    .reset       (reset),
    .halt        (halt),
    .data_i      (data_i),
    .data_o      (data_o),
    .data_en     (data_en),
    .sync        (sync),
    .cmd         (cmd),
    .pc_load     (pc_load),
    .pc_load_addr(pc_load_addr),
    .inst_o      (inst_o),
    .inst_valid  (inst_valid),
    .cycle_o     (cycle_o),
    .pc_o        (pc_o),
    .exec_drive  (exec_drive),
    .exec_data   (exec_data),
    .exec_cmd    (exec_cmd),
    .x2_data_o   (x2_data_o),
    .x2_valid    (x2_valid)
  );

  int checks = 0;
  int errors = 0;

  // ROM contents and the address the ROM has latched from the bus.
  logic [7:0]  rom [4096];
  logic [3:0]  rom_nib [3];
  logic [11:0] rom_addr = '0;

  // Reference state: subcycle, PC, jump request, last fetch and X2 sample.
  int         m_cycle, m_pc, m_fetch, m_paddr;
  bit         m_pend, m_x2_ok;
  logic [3:0] m_x2;
  logic [7:0] m_last;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cycle = 0; m_pc = 0; m_fetch = 0; m_paddr = 0;
    m_pend = 0; m_x2_ok = 0; m_x2 = '0; m_last = '0;
    exp_q.delete();
  endtask

  task automatic check_reset_values();
    chk("rst_cycle", cycle_o, 0);
    chk("rst_pc", pc_o, 12'h000);
    chk("rst_inst", inst_o, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_x2_data", x2_data_o, 0);
    chk("rst_x2_valid", x2_valid, 0);
    chk("rst_data_en", data_en, 1);
    chk("rst_data_o", data_o, 0);
    chk("rst_sync", sync, 0);
    chk("rst_cmd", cmd, 1);
  endtask

  // One clock: apply inputs at the falling edge, check, then advance the model.
  task automatic tick(input bit h, input bit ld, input logic [11:0] la,
                      input bit ed, input logic [3:0] edat, input bit ec);
    logic [7:0] b;
    logic [3:0] e_data;
    logic       e_en, e_cmd;
    @(negedge clock);
    halt = h; pc_load = ld; pc_load_addr = la;
    exec_drive = ed; exec_data = edat; exec_cmd = ec;
    b = rom[rom_addr];
    case (m_cycle)
      3:       data_i = b[7:4];
      4:       data_i = b[3:0];
      default: data_i = 4'($urandom_range(0, 15));
    endcase
    #1;
    e_en = 1'b1; e_data = '0; e_cmd = 1'b1;
    if (m_cycle < 3)      e_data = 4'((m_pc >> (4 * m_cycle)) & 15);
    else if (m_cycle < 6) e_en = 1'b0;
    else begin
      e_en = ed; e_data = edat;
    end
    b = rom[m_fetch];
    if (m_cycle == 2) e_cmd = 1'b0;
    if (m_cycle == 4) e_cmd = (b[7:4] == 4'hE) ? 1'b0 : 1'b1;
    if (m_cycle == 6) e_cmd = ~ec;

    chk("cycle", cycle_o, m_cycle);
    chk("pc", pc_o, m_pc);
    chk("sync", sync, (m_cycle == 7));
    chk("cmd", cmd, e_cmd);
    chk("data_en", data_en, e_en);
    if (e_en) chk("data_o", data_o, e_data);
    if (m_cycle == 5 && !h) begin
      chk("inst_valid", inst_valid, 1);
      if (exp_q.size() > 0) chk("inst_o", inst_o, exp_q.pop_front());
    end else begin
      chk("inst_valid", inst_valid, 0);
    end
    chk("inst_hold", inst_o, m_last);
    chk("x2_valid", x2_valid, (m_cycle == 7 && !h && m_x2_ok));
    chk("x2_data", x2_data_o, m_x2);

    if (m_cycle < 3) rom_nib[m_cycle] = data_o;
    if (m_cycle == 2) rom_addr = {rom_nib[2], rom_nib[1], rom_nib[0]};

    @(posedge clock);
    if (!h) begin
      if (ld) begin
        m_pend = 1; m_paddr = int'(la);
      end
      case (m_cycle)
        2: m_fetch = m_pc;
        4: begin
          m_pc   = (m_pc + 1) % 4096;
          m_last = rom[m_fetch];
          exp_q.push_back(rom[m_fetch]);
        end
        6: begin
          m_x2_ok = !ed;
          if (!ed) m_x2 = data_i;
        end
        7: if (m_pend) begin
          m_pc = m_paddr; m_pend = 0;
        end
        default: ;
      endcase
      m_cycle = (m_cycle + 1) % 8;
    end
  endtask

  task automatic idle();
    tick(0, 0, 12'h000, 0, 4'h0, 0);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 8 && m_cycle != target; i++) idle();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[0]        = 8'hD5;
    rom[1]        = 8'h3C;
    rom[12'h0A0]  = 8'hE2;
    rom[12'h3A7]  = 8'h71;
    rom[12'hFFF]  = 8'h4B;
    model_reset();

    // Reset state, then release away from the rising edge.
    repeat (2) @(posedge clock);
    #1;
    check_reset_values();
    @(posedge clock);
    #2 reset = 1'b1;

    // Fetch address 0 (D5), then address 1.
    repeat (16) idle();

    // Jump requested in A2: the M2 increment is discarded.
    run_to(1);
    tick(0, 1, 12'h3A7, 0, 4'h0, 0);
    repeat (15) idle();

    // PC wraps from FFF to 000.
    run_to(0);
    tick(0, 1, 12'hFFF, 0, 4'h0, 0);
    repeat (23) idle();

    // I/O-group instruction with the execution stage driving X2/X3.
    run_to(0);
    tick(0, 1, 12'h0A0, 0, 4'h0, 0);
    run_to(0);
    repeat (6) idle();
    tick(0, 0, 12'h000, 1, 4'h9, 0);
    tick(0, 0, 12'h000, 1, 4'h9, 0);

    // Halt for 5 clocks in M1, then resume.
    run_to(3);
    repeat (5) tick(1, 0, 12'h000, 0, 4'h0, 0);
    repeat (16) idle();

    // Randomized traffic.
    for (int i = 0; i < 480; i++) begin
      tick(($urandom_range(0, 9) == 0),
           ($urandom_range(0, 11) == 0),
           12'($urandom_range(0, 4095)),
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in X1 takes effect without a clock edge.
    run_to(5);
    #2;
    reset = 1'b0; halt = 1'b0; pc_load = 1'b0;
    exec_drive = 1'b0; exec_cmd = 1'b0; exec_data = '0;
    #1;
    check_reset_values();
    model_reset();
    rom_addr = '0;
    @(posedge clock);
    #2 reset = 1'b1;
    repeat (16) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- CPU-side bus master for the 4-bit multiplexed instruction bus that the ROM chips serve.
- Owns the 8-subcycle bus sequence (A1 A2 A3 M1 M2 X1 X2 X3 = cycles 0..7) and the 12-bit program counter.
- Each instruction cycle it drives the address nibbles and captures the two instruction nibbles the ROM returns, then hands the byte to the decoder.
- During X2/X3 it drives or samples the bus on behalf of the execution stage (SRC chip select, WRR/RDR port I/O).

Parameters:
- RESET_PC, 12'h000, PC value loaded on reset.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- halt  in  1  freezes all state while high.
- data_i  in  4  bus value from ROM/RAM chips.
- data_o  out  4  value this block drives onto the bus.
- data_en  out  1  bus drive enable for data_o.
- sync  out  1  instruction-cycle marker, high during cycle 7.
- cmd  out  1  command line, active-low.
- pc_load  in  1  jump request from the execution stage.
- pc_load_addr  in  12  jump target.
- inst_o  out  8  fetched instruction {OPR,OPA}.
- inst_valid  out  1  one-cycle strobe, high in cycle 5.
- cycle_o  out  3  current subcycle.
- pc_o  out  12  current PC.
- exec_drive  in  1  execution stage drives the bus in cycles 6–7.
- exec_data  in  4  value driven when exec_drive is high.
- exec_cmd  in  1  assert cmd in cycle 6 (SRC / I/O).
- x2_data_o  out  4  bus sample taken at the end of cycle 6.
- x2_valid  out  1  strobe, high in cycle 7 when x2_data_o was sampled.

Behaviour:
- Reset (reset low, asynchronous): cycle=0, pc=RESET_PC, inst_o=0, inst_valid=0, x2_data_o=0, x2_valid=0, pending load cleared. data_en=1 and data_o=RESET_PC[3:0], because outputs decode cycle 0. sync=0, cmd=1.
- Cycle counter: 3-bit, increments every clock while !halt, wraps 7->0.
- halt: counter, PC, capture registers and pending load all hold. inst_valid and x2_valid are forced 0. data_o, data_en and cmd keep decoding the frozen cycle.
- Bus drive, combinational on cycle:
  - cycle 0: data_en=1, data_o=pc[3:0].
  - cycle 1: data_en=1, data_o=pc[7:4].
  - cycle 2: data_en=1, data_o=pc[11:8].
  - cycles 3–5: data_en=0.
  - cycles 6–7: data_en=exec_drive, data_o=exec_data.
  - any other case: data_o=0.
- cmd (active-low):
  - cycle 2: 0 (ROM select).
  - cycle 4: 0 iff the captured OPR == 4'hE (I/O group), so the selected chip latches OPA.
  - cycle 6: 0 iff exec_cmd.
  - all other cycles, including 7: 1.
- Capture: the ROM drives combinationally from a register loaded in cycle 2.
  - End of cycle 3: opr <= data_i.
  - End of cycle 4: inst_o <= {opr, data_i}, and pc <= pc+1 modulo 4096 (0xFFF wraps to 0x000).
  - inst_valid is registered: high for exactly one cycle, during cycle 5.
- Jump:
  - pc_load high in any cycle sets a pending flag and latches pc_load_addr; the last request wins.
  - The pending load is applied at the end of cycle 7: pc <= latched address, flag cleared.
  - A request in cycle 7 itself is applied at that same edge.
  - A load always overrides the cycle-4 increment of the same instruction cycle.
- X2 sample: at the end of cycle 6, if !exec_drive, x2_data_o <= data_i and x2_valid goes high during cycle 7. If exec_drive, x2_data_o holds and x2_valid stays 0.
- sync: registered, high exactly while cycle==7.
- cycle_o and pc_o: direct register views.

Decomposition:
- Shared package/defines:
  - subcycle constants CYC_A1..CYC_X3 (0..7);
  - OPR_IO = 4'hE;
  - PC_BITS = 12;
  - nibble width.
- The ROM/RAM chips use the same constants.
- One natural sub-module: fetch_pc. It holds the 12-bit PC with increment, pending load and the priority rule. The bus sequencing stays in fetch_unit.

Test Plan:
- Reset release with RESET_PC=0 -> cycles 0,1,2 drive 0,0,0. cmd low only in cycle 2. sync high in cycle 7. pc_o=1 after the first cycle-4 edge.
- ROM model returns 8'hD5 for address 0 -> inst_o=8'hD5 with inst_valid high in cycle 5 only. Next fetch drives address nibbles 1,0,0.
- pc_load=1 with pc_load_addr=12'h3A7 pulsed in cycle 1 -> next A1..A3 drive 7,A,3. The intermediate increment is discarded.
- PC at 12'hFFF, no load -> after fetch, next address nibbles are 0,0,0.
- Fetched OPR=E, OPA=2 with exec_drive=1, exec_data=4'h9 -> cmd low in cycles 2 and 4. data_en=1 and data_o=9 in cycles 6–7. x2_valid stays 0.
- halt held 5 clocks at cycle 3, then released -> cycle_o stays 3 and no strobes fire during the halt. Capture resumes correctly. Asserting reset low at cycle 5 immediately gives cycle 0 and pc=RESET_PC.
